cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 35 +++
 rtl/cdb_fifo.sv | 79 +++++++
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared widths, source encoding and result layout for the common data bus arbiter.
package cdb_pkg;

  localparam int DATA_W     = 32;
  localparam int TAG_W      = 5;
  localparam int DEST_W     = 5;
  localparam int FIFO_DEPTH = 2;

  // Which execution unit produced a broadcast result.
  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } cdb_src_e;

  // One completed result as it travels through a source buffer.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } cdb_result_t;

  localparam int RESULT_W = $bits(cdb_result_t);

  // Round-robin choice between the two sources. `pri` names the source that
  // wins a tie; a lone non-empty source always wins. Only meaningful when at
  // least one source is non-empty.
  function automatic cdb_src_e rr_pick(input logic add_ne, input logic mul_ne,
                                       input cdb_src_e pri);
    if (add_ne && (!mul_ne || pri == SRC_ADD)) begin
      return SRC_ADD;
    end
    return SRC_MUL;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous result buffer with an occupancy count. The head entry is
// read combinationally so the arbiter can grant and pop it in the same cycle.
module cdb_fifo #(
  parameter  int W     = 42,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,    // synchronous, active low
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en;
  logic             pop_en;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A flush cancels any push or pop presented in the same cycle.
  assign push_en = push && (cnt_q != DEPTH_C) && !flush;
  assign pop_en  = pop && (cnt_q != '0) && !flush;

  // Next-state pointers and count; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_en && !pop_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_en && !push_en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state: reset and flush both return the buffer to empty.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (rst && push_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers adder and multiplier results and
// broadcasts one per cycle, alternating between sources when both wait.
module cdb_arbiter #(
  parameter  int DATA_W     = cdb_pkg::DATA_W,
  parameter  int TAG_W      = cdb_pkg::TAG_W,
  parameter  int FIFO_DEPTH = cdb_pkg::FIFO_DEPTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,       // synchronous, active low
  input  logic                       flush,
  // adder result port
  input  logic                       add_valid,
  output logic                       add_ready,
  input  logic [TAG_W-1:0]           add_tag,
  input  logic [cdb_pkg::DEST_W-1:0] add_dest,
  input  logic [DATA_W-1:0]          add_data,
  // multiplier result port
  input  logic                       mul_valid,
  output logic                       mul_ready,
  input  logic [TAG_W-1:0]           mul_tag,
  input  logic [cdb_pkg::DEST_W-1:0] mul_dest,
  input  logic [DATA_W-1:0]          mul_data,
  // broadcast
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [cdb_pkg::DEST_W-1:0] cdb_dest,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_src,
  // occupancy
  output logic [CNT_W-1:0]           add_cnt,
  output logic [CNT_W-1:0]           mul_cnt
);

  import cdb_pkg::*;

  localparam int RES_W = TAG_W + DEST_W + DATA_W;
  localparam int NSRC  = 2;   // index 0 = adder, 1 = multiplier (matches cdb_src)
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [NSRC-1:0]  in_valid;
  logic [NSRC-1:0]  in_ready;
  logic [NSRC-1:0]  push;
  logic [NSRC-1:0]  pop;
  logic [NSRC-1:0]  not_empty;
  logic [RES_W-1:0] in_res   [NSRC];
  logic [RES_W-1:0] head_res [NSRC];
  logic [CNT_W-1:0] occ      [NSRC];

  logic             grant_any;
  cdb_src_e         grant_src;
  logic [RES_W-1:0] grant_res;

  cdb_src_e              pri_q;
  logic                  cdb_valid_q;
  logic [TAG_W-1:0]      cdb_tag_q;
  logic [DEST_W-1:0]     cdb_dest_q;
  logic [DATA_W-1:0]     cdb_data_q;
  cdb_src_e              cdb_src_q;

  assign in_valid  = {mul_valid, add_valid};
  assign in_res[0] = {add_tag, add_dest, add_data};
  assign in_res[1] = {mul_tag, mul_dest, mul_data};

  // One buffer per source; ready comes only from the registered count, so a
  // full buffer never accepts on the strength of a same-cycle pop.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    cdb_fifo #(
      .W     (RES_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[gi]),
      .din   (in_res[gi]),
      .pop   (pop[gi]),
      .head  (head_res[gi]),
      .cnt   (occ[gi])
    );

    assign in_ready[gi]  = (occ[gi] < DEPTH_C);
    assign not_empty[gi] = (occ[gi] != '0);
    assign push[gi]      = in_valid[gi] & in_ready[gi];
  end

  assign add_ready = in_ready[0];
  assign mul_ready = in_ready[1];
  assign add_cnt   = occ[0];
  assign mul_cnt   = occ[1];

  // Pick a head to broadcast this cycle and pop it from its buffer.
  always_comb begin
    grant_any = |not_empty;
    grant_src = rr_pick(not_empty[0], not_empty[1], pri_q);
    pop       = '0;
    pop[0]    = grant_any && !flush && (grant_src == SRC_ADD);
    pop[1]    = grant_any && !flush && (grant_src == SRC_MUL);
    grant_res = (grant_src == SRC_ADD) ? head_res[0] : head_res[1];
  end

  // Broadcast registers and round-robin pointer; fields hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_dest_q  <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= SRC_ADD;
      pri_q       <= SRC_ADD;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
      pri_q       <= SRC_ADD;
    end else if (grant_any) begin
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= grant_res[RES_W-1 -: TAG_W];
      cdb_dest_q  <= grant_res[DATA_W +: DEST_W];
      cdb_data_q  <= grant_res[DATA_W-1:0];
      cdb_src_q   <= grant_src;
      pri_q       <= (grant_src == SRC_ADD) ? SRC_MUL : SRC_ADD;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_dest  = cdb_dest_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule
